csr_access_ctrl: RTL and testbench

- Initiator side of the machine-mode CSR port.
- Accepts one decoded Zicsr instruction (CSRRW/S/C and immediate forms) from the execute stage.
- Sequences the read and write strobes toward the CSR register file with correct rs1/uimm/rd = x0 side-effect rules, and returns the old CSR value for writeback over a valid/ready response channel.
- Flags illegal accesses (unimplemented CSR, or write to a read-only CSR) to the trap logic instead of performing them.

---
 rtl/csr_access_if.sv | 45 ++++
 rtl/csr_access_ctrl.sv | 166 ++++++++++++++++
 tb/tb_csr_access_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/csr_access_if.sv
// Bundles the request, CSR register-file and writeback-response channels of
// the machine-mode CSR access controller. The controller uses the slave
// modport; the surrounding pipeline/register file side uses master.
interface csr_access_if #(
    parameter int XLEN = 32
);
    // Request channel from the execute stage
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [11:0]     req_csr;
    logic [4:0]      req_rs1_idx;
    logic [XLEN-1:0] req_rs1_val;
    logic [4:0]      req_rd_idx;

    // CSR register-file port
    logic [11:0]     csr_addr;
    logic            csr_rd_en;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_hit;
    logic            csr_wr_en;
    logic [XLEN-1:0] csr_wdata;

    // Writeback response channel
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_rd_we;
    logic [4:0]      rsp_rd_idx;
    logic [XLEN-1:0] rsp_rd_data;
    logic            rsp_illegal;

    modport master (
        output req_valid, req_funct3, req_csr, req_rs1_idx, req_rs1_val, req_rd_idx,
        output csr_rdata, csr_hit, rsp_ready,
        input  req_ready, csr_addr, csr_rd_en, csr_wr_en, csr_wdata,
        input  rsp_valid, rsp_rd_we, rsp_rd_idx, rsp_rd_data, rsp_illegal
    );

    modport slave (
        input  req_valid, req_funct3, req_csr, req_rs1_idx, req_rs1_val, req_rd_idx,
        input  csr_rdata, csr_hit, rsp_ready,
        output req_ready, csr_addr, csr_rd_en, csr_wr_en, csr_wdata,
        output rsp_valid, rsp_rd_we, rsp_rd_idx, rsp_rd_data, rsp_illegal
    );
endinterface

// File: rtl/csr_access_ctrl.sv
// Machine-mode CSR access controller (initiator side of the CSR port).
// Takes one decoded Zicsr instruction, performs the read (side-effecting
// only when architecturally required), then the one-cycle write if any, and
// returns the old CSR value over a valid/ready response channel. Illegal
// accesses are reported instead of performed.
// Optional feature macro: CSR_RO_CHECK_EN -- when defined, writes to the
// read-only CSR range (csr[11:10] == 2'b11) are flagged illegal.
module csr_access_ctrl #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    csr_access_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    // Latched instruction. Only funct3[1:0] selects the operation; the
    // immediate bit is consumed when the operand is formed at accept time.
    logic [1:0]      kind_reg;
    logic            f3_ok_reg;
    logic [11:0]     csr_reg;
    logic [4:0]      rs1_idx_reg;
    logic [XLEN-1:0] op_reg;
    logic [4:0]      rd_reg;
    logic [XLEN-1:0] old_reg;
    logic            illegal_reg;

    logic            is_rw;
    logic            is_rs;
    logic            do_write;
    logic            do_read;
    logic            ro_violation;
    logic            illegal_now;
    logic [XLEN-1:0] wdata_calc;
    logic [XLEN-1:0] op_in;

    // Operand: zero-extended zimm for the immediate forms, else rs1 value.
    assign op_in = bus.req_funct3[2] ? {{(XLEN-5){1'b0}}, bus.req_rs1_idx}
                                     : bus.req_rs1_val;

    // Side-effect rules: set/clear with rs1/zimm == 0 never write;
    // RW/RWI with rd == 0 never read.
    assign is_rw    = (kind_reg == 2'b01);
    assign is_rs    = (kind_reg == 2'b10);
    assign do_write = is_rw || (rs1_idx_reg != 5'd0);
    assign do_read  = !is_rw || (rd_reg != 5'd0);

`ifdef CSR_RO_CHECK_EN
    assign ro_violation = do_write && (csr_reg[11:10] == 2'b11);
`else
    assign ro_violation = 1'b0;
`endif

    // Evaluated during READ, while csr_addr presents the latched address.
    assign illegal_now = !f3_ok_reg || !bus.csr_hit || ro_violation;

    // Write value from the old value captured in READ.
    always_comb begin
        wdata_calc = op_reg;
        if (is_rs) begin
            wdata_calc = old_reg | op_reg;
        end else if (kind_reg == 2'b11) begin
            wdata_calc = old_reg & ~op_reg;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Instruction latch at accept, old value and illegal flag capture in READ.
    always_ff @(posedge clk) begin
        if (rst) begin
            kind_reg    <= 2'b00;
            f3_ok_reg   <= 1'b0;
            csr_reg     <= 12'd0;
            rs1_idx_reg <= 5'd0;
            op_reg      <= '0;
            rd_reg      <= 5'd0;
            old_reg     <= '0;
            illegal_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && bus.req_valid) begin
                kind_reg    <= bus.req_funct3[1:0];
                f3_ok_reg   <= (bus.req_funct3[1:0] != 2'b00);
                csr_reg     <= bus.req_csr;
                rs1_idx_reg <= bus.req_rs1_idx;
                op_reg      <= op_in;
                rd_reg      <= bus.req_rd_idx;
            end
            if (state_reg == READ) begin
                old_reg     <= (do_read && !illegal_now) ? bus.csr_rdata : '0;
                illegal_reg <= illegal_now;
            end
        end
    end

    // Next-state and output decode; strobes and rsp_valid are held off while
    // rst is asserted so nothing is issued once reset has been sampled.
    always_comb begin
        state_next      = state_reg;
        bus.req_ready   = 1'b0;
        bus.csr_addr    = 12'd0;
        bus.csr_rd_en   = 1'b0;
        bus.csr_wr_en   = 1'b0;
        bus.csr_wdata   = '0;
        bus.rsp_valid   = 1'b0;
        bus.rsp_rd_we   = 1'b0;
        bus.rsp_rd_idx  = 5'd0;
        bus.rsp_rd_data = '0;
        bus.rsp_illegal = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_next = READ;
                end
            end
            READ: begin
                bus.csr_addr  = csr_reg;
                bus.csr_rd_en = do_read && !illegal_now && !rst;
                if (illegal_now) begin
                    state_next = RESP;
                end else if (do_write) begin
                    state_next = WRITE;
                end else begin
                    state_next = RESP;
                end
            end
            WRITE: begin
                bus.csr_addr  = csr_reg;
                bus.csr_wr_en = !rst;
                bus.csr_wdata = wdata_calc;
                state_next    = RESP;
            end
            RESP: begin
                bus.rsp_valid   = !rst;
                bus.rsp_rd_we   = !illegal_reg && (rd_reg != 5'd0);
                bus.rsp_rd_idx  = rd_reg;
                bus.rsp_rd_data = old_reg;
                bus.rsp_illegal = illegal_reg;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed, table-driven bench for csr_access_ctrl. Expected values are hand
// computed from the instruction semantics; expectations for read-only CSR
// writes follow the CSR_RO_CHECK_EN build option.
module tb_csr_access_ctrl;

    logic clk;
    logic rst;

    csr_access_if #(.XLEN(32)) bus ();

    csr_access_ctrl #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] csr;
        logic [4:0]  rs1_idx;
        logic [31:0] rs1_val;
        logic [4:0]  rd;
        logic [31:0] old;
        logic        hit;
        int          exp_rd_en;
        int          exp_wr;
        logic [31:0] exp_wdata;
        logic        exp_rd_we;
        logic [31:0] exp_rd_data;
        logic        exp_ill;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    int tests;
    int fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one instruction, watch the strobes cycle by cycle, optionally hold
    // rsp_ready low for 'hold' cycles once the response is up, then complete.
    task automatic issue(input int id, input vec_t v, input int hold);
        int          rd_cnt;
        int          wr_cnt;
        int          overlap;
        int          lat;
        logic [31:0] wd;
        logic [11:0] wa;
        logic        cap_we;
        logic [4:0]  cap_idx;
        logic [31:0] cap_data;
        logic        cap_ill;
        rd_cnt = 0; wr_cnt = 0; overlap = 0; lat = -1;
        wd = 32'd0; wa = 12'd0;
        cap_we = 1'b0; cap_idx = 5'd0; cap_data = 32'd0; cap_ill = 1'b0;

        @(negedge clk);
        bus.rsp_ready   = (hold == 0);
        bus.req_valid   = 1'b1;
        bus.req_funct3  = v.f3;
        bus.req_csr     = v.csr;
        bus.req_rs1_idx = v.rs1_idx;
        bus.req_rs1_val = v.rs1_val;
        bus.req_rd_idx  = v.rd;
        bus.csr_rdata   = v.old;
        bus.csr_hit     = v.hit;
        check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;

        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (bus.csr_rd_en) rd_cnt++;
            if (bus.csr_wr_en) begin
                wr_cnt++;
                wd = bus.csr_wdata;
                wa = bus.csr_addr;
            end
            if (bus.csr_rd_en && bus.csr_wr_en) overlap++;
            if (bus.rsp_valid) begin
                lat      = k;
                cap_we   = bus.rsp_rd_we;
                cap_idx  = bus.rsp_rd_idx;
                cap_data = bus.rsp_rd_data;
                cap_ill  = bus.rsp_illegal;
            end
        end

        $display("[TB] vec %0d f3=%b csr=0x%03h rd_en=%0d wr=%0d wdata=0x%08h rd_we=%b rd_data=0x%08h ill=%b lat=%0d",
                 id, v.f3, v.csr, rd_cnt, wr_cnt, wd, cap_we, cap_data, cap_ill, lat);

        check("rsp_latency", lat, v.exp_lat);
        check("rd_en_count", rd_cnt, v.exp_rd_en);
        check("wr_en_count", wr_cnt, v.exp_wr);
        check("rd_wr_overlap", overlap, 0);
        check("wdata", wd, v.exp_wdata);
        check("waddr", {20'd0, wa}, (v.exp_wr != 0) ? {20'd0, v.csr} : 32'd0);
        check("rsp_rd_we", {31'd0, cap_we}, {31'd0, v.exp_rd_we});
        check("rsp_rd_idx", {27'd0, cap_idx}, {27'd0, v.rd});
        check("rsp_rd_data", cap_data, v.exp_rd_data);
        check("rsp_illegal", {31'd0, cap_ill}, {31'd0, v.exp_ill});

        if (lat >= 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
                check("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
                check("hold_rd_data", bus.rsp_rd_data, v.exp_rd_data);
                check("hold_rd_we", {31'd0, bus.rsp_rd_we}, {31'd0, v.exp_rd_we});
            end
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("back_idle_valid", {31'd0, bus.rsp_valid}, 32'd0);
            check("back_idle_ready", {31'd0, bus.req_ready}, 32'd1);
        end
    endtask

    initial begin
        int bad;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_funct3  = 3'd0;
        bus.req_csr     = 12'd0;
        bus.req_rs1_idx = 5'd0;
        bus.req_rs1_val = 32'd0;
        bus.req_rd_idx  = 5'd0;
        bus.csr_rdata   = 32'd0;
        bus.csr_hit     = 1'b0;
        bus.rsp_ready   = 1'b1;

        //            f3      csr     rs1 rs1_val        rd  old           hit rde wr wdata          we  rd_data       ill lat
        vecs[0]  = '{3'b001, 12'h340, 5'd7,  32'hDEADBEEF, 5'd5,  32'h12345678, 1'b1, 1, 1, 32'hDEADBEEF, 1'b1, 32'h12345678, 1'b0, 3};
        vecs[1]  = '{3'b001, 12'h340, 5'd7,  32'h0000A5A5, 5'd0,  32'h00001111, 1'b1, 0, 1, 32'h0000A5A5, 1'b0, 32'h00000000, 1'b0, 3};
        vecs[2]  = '{3'b010, 12'h300, 5'd0,  32'hFFFFFFFF, 5'd3,  32'h00001888, 1'b1, 1, 0, 32'h00000000, 1'b1, 32'h00001888, 1'b0, 2};
        vecs[3]  = '{3'b111, 12'h340, 5'd3,  32'hFFFFFFFF, 5'd4,  32'h0000000F, 1'b1, 1, 1, 32'h0000000C, 1'b1, 32'h0000000F, 1'b0, 3};
        vecs[4]  = '{3'b010, 12'h304, 5'd2,  32'h000000F0, 5'd1,  32'h0000000F, 1'b1, 1, 1, 32'h000000FF, 1'b1, 32'h0000000F, 1'b0, 3};
        vecs[5]  = '{3'b011, 12'h304, 5'd9,  32'h0000000F, 5'd2,  32'h000000FF, 1'b1, 1, 1, 32'h000000F0, 1'b1, 32'h000000FF, 1'b0, 3};
        vecs[6]  = '{3'b101, 12'h341, 5'd31, 32'hFFFFFFFF, 5'd6,  32'h00000077, 1'b1, 1, 1, 32'h0000001F, 1'b1, 32'h00000077, 1'b0, 3};
        vecs[7]  = '{3'b110, 12'h341, 5'd0,  32'hFFFFFFFF, 5'd7,  32'h00000055, 1'b1, 1, 0, 32'h00000000, 1'b1, 32'h00000055, 1'b0, 2};
        vecs[8]  = '{3'b100, 12'h340, 5'd1,  32'h00000001, 5'd8,  32'h00000099, 1'b1, 0, 0, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 2};
        vecs[9]  = '{3'b000, 12'h340, 5'd1,  32'h00000001, 5'd8,  32'h00000099, 1'b1, 0, 0, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 2};
        vecs[10] = '{3'b001, 12'h7C0, 5'd1,  32'h00000123, 5'd9,  32'h00000099, 1'b0, 0, 0, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 2};
`ifdef CSR_RO_CHECK_EN
        vecs[11] = '{3'b001, 12'hF11, 5'd4,  32'h00000F11, 5'd10, 32'h0000ABCD, 1'b1, 0, 0, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 2};
`else
        vecs[11] = '{3'b001, 12'hF11, 5'd4,  32'h00000F11, 5'd10, 32'h0000ABCD, 1'b1, 1, 1, 32'h00000F11, 1'b1, 32'h0000ABCD, 1'b0, 3};
`endif
        vecs[12] = '{3'b010, 12'hF11, 5'd0,  32'h00000F11, 5'd11, 32'h0000ABCD, 1'b1, 1, 0, 32'h00000000, 1'b1, 32'h0000ABCD, 1'b0, 2};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rd_en", {31'd0, bus.csr_rd_en}, 32'd0);
        check("rst_wr_en", {31'd0, bus.csr_wr_en}, 32'd0);
        check("rst_csr_addr", {20'd0, bus.csr_addr}, 32'd0);
        check("rst_wdata", bus.csr_wdata, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_fields", {bus.rsp_rd_data[25:0], bus.rsp_rd_idx, bus.rsp_rd_we} | {31'd0, bus.rsp_illegal}, 32'd0);
        $display("[TB] reset state checked");
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            issue(i, vecs[i], 0);
        end

        // Response backpressure: rsp_ready low for 5 cycles
        $display("[TB] backpressure sequence");
        issue(100, vecs[0], 5);

        // Reset while in WRITE
        $display("[TB] reset-in-WRITE sequence");
        @(negedge clk);
        bus.rsp_ready   = 1'b1;
        bus.req_valid   = 1'b1;
        bus.req_funct3  = 3'b001;
        bus.req_csr     = 12'h340;
        bus.req_rs1_idx = 5'd7;
        bus.req_rs1_val = 32'h0BADF00D;
        bus.req_rd_idx  = 5'd5;
        bus.csr_rdata   = 32'h11112222;
        bus.csr_hit     = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstw_in_write", {31'd0, bus.csr_wr_en}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstw_wr_en", {31'd0, bus.csr_wr_en}, 32'd0);
        check("rstw_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rstw_req_ready", {31'd0, bus.req_ready}, 32'd1);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.csr_wr_en || bus.rsp_valid || !bus.req_ready) bad++;
        end
        check("rstw_dropped", bad, 0);
        $display("[TB] reset-in-WRITE: post-reset activity cycles=%0d", bad);

        // Normal operation resumes after the mid-operation reset
        issue(101, vecs[3], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
